// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle Moore control unit sequencing IF/ID/EX/MEM/WB for the MIPS-subset datapath.
// Optional build macro ILLEGAL_TRAP_EN: undecodable instructions trap in S_ERR instead of running as NOPs.
module mc_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [5:0]      OP,
    input  logic [5:0]      func,
    output logic            PC_Write,
    output logic            IR_Write,
    output logic            Write_Reg,
    output logic            Mem_Write,
    output logic            Set_ZF,
    output logic            Set_OF,
    output logic [2:0]      ALU_OP,
    output logic            rd_rt_s,
    output logic            imm_s,
    output logic            rt_imm_s,
    output logic            alu_mem_s,
    output logic            inst_done,
    output logic            halted,
    output logic [ST_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000100;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = ST_W'(0),
        S_IF   = ST_W'(1),
        S_ID   = ST_W'(2),
        S_EX   = ST_W'(3),
        S_MEM  = ST_W'(4),
        S_WB   = ST_W'(5),
        S_ERR  = ST_W'(6)
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_IALU,
        C_LW,
        C_SW,
        C_BAD
    } cls_t;

    // Everything latched at the end of S_ID and held for the rest of the instruction.
    typedef struct packed {
        cls_t       cls;
        logic [2:0] alu_op;
        logic       set_zf;
        logic       set_of;
        logic       rd_rt_s;
        logic       imm_s;
        logic       rt_imm_s;
        logic       alu_mem_s;
    } ctl_t;

    localparam ctl_t CTL_NOP = '{C_BAD, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    state_t state_q;
    state_t state_d;
    ctl_t   dec;
    ctl_t   ctl_q;

    // Instruction decode from the live IR fields; only sampled while in S_ID.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        dec = CTL_NOP;
        case (OP)
            OP_RTYPE: begin
                dec.cls    = C_RTYPE;
                dec.set_zf = 1'b1;
                case (func)
                    F_ADD: begin
                        dec.alu_op = ALU_ADD;
                        dec.set_of = 1'b1;
                    end
                    F_SUB: begin
                        dec.alu_op = ALU_SUB;
                        dec.set_of = 1'b1;
                    end
                    F_AND:   dec.alu_op = ALU_AND;
                    F_OR:    dec.alu_op = ALU_OR;
                    F_XOR:   dec.alu_op = ALU_XOR;
                    F_NOR:   dec.alu_op = ALU_NOR;
                    F_SLTU:  dec.alu_op = ALU_SLTU;
                    F_SLL:   dec.alu_op = ALU_SLL;
                    default: dec = CTL_NOP;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_XORI, OP_SLTIU: begin
                dec.cls      = C_IALU;
                dec.set_zf   = 1'b1;
                dec.rd_rt_s  = 1'b1;
                dec.rt_imm_s = 1'b1;
                case (OP)
                    OP_ADDI: begin
                        dec.alu_op = ALU_ADD;
                        dec.imm_s  = 1'b1;
                        dec.set_of = 1'b1;
                    end
                    OP_ANDI: dec.alu_op = ALU_AND;
                    OP_XORI: dec.alu_op = ALU_XOR;
                    default: dec.alu_op = ALU_SLTU;
                endcase
            end
            OP_LW: begin
                dec.cls       = C_LW;
                dec.alu_op    = ALU_ADD;
                dec.imm_s     = 1'b1;
                dec.rt_imm_s  = 1'b1;
                dec.rd_rt_s   = 1'b1;
                dec.alu_mem_s = 1'b1;
            end
            OP_SW: begin
                dec.cls      = C_SW;
                dec.alu_op   = ALU_ADD;
                dec.imm_s    = 1'b1;
                dec.rt_imm_s = 1'b1;
            end
            default: dec = CTL_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the control register is reset along with the state so selects and ALU_OP come up at known idle values.
            state_q <= S_IDLE;
            ctl_q   <= CTL_NOP;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            if (state_q == S_ID) begin
                ctl_q <= dec;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = run ? S_IF : S_IDLE;
            S_IF:   state_d = S_ID;
            S_ID: begin
                if (dec.cls == C_BAD) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_ERR;
`else
                    state_d = S_WB;
`endif
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX:   state_d = (ctl_q.cls == C_LW || ctl_q.cls == C_SW) ? S_MEM : S_WB;
            S_MEM: begin
                if (ctl_q.cls == C_SW) begin
                    state_d = run ? S_IF : S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB:   state_d = run ? S_IF : S_IDLE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobes: a function of the current state and the latched class only.
    always_comb begin
        PC_Write  = 1'b0;
        IR_Write  = 1'b0;
        Write_Reg = 1'b0;
        Mem_Write = 1'b0;
        Set_ZF    = 1'b0;
        Set_OF    = 1'b0;
        inst_done = 1'b0;
        case (state_q)
            S_IF: begin
                PC_Write = 1'b1;
                IR_Write = 1'b1;
            end
            S_EX: begin
                Set_ZF = ctl_q.set_zf;
                Set_OF = ctl_q.set_of;
            end
            S_MEM: begin
                if (ctl_q.cls == C_SW) begin
                    Mem_Write = 1'b1;
                    inst_done = 1'b1;
                end
            end
            S_WB: begin
                Write_Reg = (ctl_q.cls != C_BAD);
                inst_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign ALU_OP    = ctl_q.alu_op;
    assign rd_rt_s   = ctl_q.rd_rt_s;
    assign imm_s     = ctl_q.imm_s;
    assign rt_imm_s  = ctl_q.rt_imm_s;
    assign alu_mem_s = ctl_q.alu_mem_s;
    assign halted    = (state_q == S_IDLE);
    assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl; expected values are hand-derived constants.
// Follows the ILLEGAL_TRAP_EN macro so the illegal-opcode expectations match the build.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic       run;
    logic [5:0] OP;
    logic [5:0] func;
    logic       PC_Write, IR_Write, Write_Reg, Mem_Write, Set_ZF, Set_OF;
    logic [2:0] ALU_OP;
    logic       rd_rt_s, imm_s, rt_imm_s, alu_mem_s;
    logic       inst_done, halted;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // {PC_Write, IR_Write, Write_Reg, Mem_Write, Set_ZF, Set_OF, inst_done}
    logic [6:0] strb;
    // {rd_rt_s, imm_s, rt_imm_s, alu_mem_s}
    logic [3:0] sel;
    assign strb = {PC_Write, IR_Write, Write_Reg, Mem_Write, Set_ZF, Set_OF, inst_done};
    assign sel  = {rd_rt_s, imm_s, rt_imm_s, alu_mem_s};

    localparam logic [6:0] SB_NONE  = 7'b0000000;
    localparam logic [6:0] SB_IF    = 7'b1100000;
    localparam logic [6:0] SB_WB    = 7'b0010001;
    localparam logic [6:0] SB_SW    = 7'b0001001;
    localparam logic [6:0] SB_NOPWB = 7'b0000001;
    localparam logic [6:0] SB_LDEX  = 7'b0000000;

    mc_ctrl #(.ST_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .OP        (OP),
        .func      (func),
        .PC_Write  (PC_Write),
        .IR_Write  (IR_Write),
        .Write_Reg (Write_Reg),
        .Mem_Write (Mem_Write),
        .Set_ZF    (Set_ZF),
        .Set_OF    (Set_OF),
        .ALU_OP    (ALU_OP),
        .rd_rt_s   (rd_rt_s),
        .imm_s     (imm_s),
        .rt_imm_s  (rt_imm_s),
        .alu_mem_s (alu_mem_s),
        .inst_done (inst_done),
        .halted    (halted),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check state, strobe vector and halted against expectations.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] sb);
        @(posedge clk);
        #1;
        check({tag, "_state"}, 8'(state), 8'(st));
        check({tag, "_strb"}, 8'(strb), 8'(sb));
        check({tag, "_halted"}, 8'(halted), 8'(st == 4'd0));
    endtask

    task automatic check_ctl(input string tag, input logic [2:0] alu, input logic [3:0] s);
        check({tag, "_aluop"}, 8'(ALU_OP), 8'(alu));
        check({tag, "_sel"}, 8'(sel), 8'(s));
    endtask

    // One R-type / I-ALU instruction: IF, ID, EX, WB. Garbage is driven on OP/func after S_ID.
    task automatic alu_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [2:0] alu, input logic of, input logic [3:0] s);
        OP   = op;
        func = fn;
        cyc({tag, "_if"}, 4'd1, SB_IF);
        cyc({tag, "_id"}, 4'd2, SB_NONE);
        cyc({tag, "_ex"}, 4'd3, {4'b0000, 1'b1, of, 1'b0});
        check_ctl({tag, "_ex"}, alu, s);
        OP   = 6'b111111;
        func = 6'b111111;
        cyc({tag, "_wb"}, 4'd5, SB_WB);
        check_ctl({tag, "_wb"}, alu, s);
    endtask

    initial begin
        rst  = 1'b0;
        run  = 1'b0;
        OP   = 6'b000000;
        func = 6'b000000;
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 8'(state), 8'd0);
        check("rst_strb", 8'(strb), 8'(SB_NONE));
        check("rst_halted", 8'(halted), 8'd1);
        check_ctl("rst", 3'b100, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc("idle", 4'd0, SB_NONE);

        // R-type and I-ALU instructions back to back with run held high.
        run = 1'b1;
        alu_instr("sub",   6'b000000, 6'b100010, 3'b101, 1'b1, 4'b0000);
        alu_instr("add",   6'b000000, 6'b100000, 3'b100, 1'b1, 4'b0000);
        alu_instr("and",   6'b000000, 6'b100100, 3'b000, 1'b0, 4'b0000);
        alu_instr("or",    6'b000000, 6'b100101, 3'b001, 1'b0, 4'b0000);
        alu_instr("xor",   6'b000000, 6'b100110, 3'b010, 1'b0, 4'b0000);
        alu_instr("nor",   6'b000000, 6'b100111, 3'b011, 1'b0, 4'b0000);
        alu_instr("sltu",  6'b000000, 6'b101011, 3'b110, 1'b0, 4'b0000);
        alu_instr("sll",   6'b000000, 6'b000100, 3'b111, 1'b0, 4'b0000);
        alu_instr("addi",  6'b001000, 6'b010101, 3'b100, 1'b1, 4'b1110);
        alu_instr("andi",  6'b001100, 6'b000000, 3'b000, 1'b0, 4'b1010);
        alu_instr("xori",  6'b001110, 6'b000000, 3'b010, 1'b0, 4'b1010);
        alu_instr("sltiu", 6'b001011, 6'b000000, 3'b110, 1'b0, 4'b1010);

        // lw: five cycles, selects held from EX to WB despite OP changing.
        OP   = 6'b100011;
        func = 6'b000000;
        cyc("lw_if", 4'd1, SB_IF);
        cyc("lw_id", 4'd2, SB_NONE);
        cyc("lw_ex", 4'd3, SB_LDEX);
        check_ctl("lw_ex", 3'b100, 4'b1111);
        OP   = 6'b000000;
        func = 6'b100100;
        cyc("lw_mem", 4'd4, SB_NONE);
        check_ctl("lw_mem", 3'b100, 4'b1111);
        cyc("lw_wb", 4'd5, SB_WB);
        check_ctl("lw_wb", 3'b100, 4'b1111);

        // sw with run dropped mid-instruction: completes in S_MEM, then idles.
        OP = 6'b101011;
        cyc("sw_if", 4'd1, SB_IF);
        cyc("sw_id", 4'd2, SB_NONE);
        run = 1'b0;
        cyc("sw_ex", 4'd3, SB_NONE);
        check_ctl("sw_ex", 3'b100, 4'b0110);
        cyc("sw_mem", 4'd4, SB_SW);
        cyc("sw_idle0", 4'd0, SB_NONE);
        cyc("sw_idle1", 4'd0, SB_NONE);

        // Illegal opcode.
        OP  = 6'b111111;
        run = 1'b1;
        cyc("bad_if", 4'd1, SB_IF);
        cyc("bad_id", 4'd2, SB_NONE);
        run = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) cyc("bad_err", 4'd6, SB_NONE);
`else
        cyc("bad_wb", 4'd5, SB_NOPWB);
        check_ctl("bad_wb", 3'b100, 4'b0000);
        cyc("bad_idle", 4'd0, SB_NONE);
`endif
        rst = 1'b1;
        #1;
        check("bad_rst_state", 8'(state), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst_idle", 4'd0, SB_NONE);

        // Asynchronous reset during S_MEM of a lw.
        OP  = 6'b100011;
        run = 1'b1;
        cyc("lwr_if", 4'd1, SB_IF);
        cyc("lwr_id", 4'd2, SB_NONE);
        cyc("lwr_ex", 4'd3, SB_LDEX);
        cyc("lwr_mem", 4'd4, SB_NONE);
        run = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("lwr_async_state", 8'(state), 8'd0);
        check("lwr_async_strb", 8'(strb), 8'(SB_NONE));
        check("lwr_async_halted", 8'(halted), 8'd1);
        check_ctl("lwr_async", 3'b100, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("lwr_hold_state", 8'(state), 8'd0);
            check("lwr_hold_wreg", 8'(Write_Reg), 8'd0);
        end
        rst = 1'b0;
        cyc("lwr_idle0", 4'd0, SB_NONE);
        cyc("lwr_idle1", 4'd0, SB_NONE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
